// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - memory bus bundle between the access unit (master) and memory (slave)
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - M-stage load/store unit: lane steering, bus handshake, timeout, load extension
// Optional MEMU_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqM,
  input  logic              weM,
  input  logic [1:0]        sizeM,
  input  logic              unsignedM,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [DATA_W-1:0] wdataM,
  output logic              stallM,
  output logic [DATA_W-1:0] rdataW,
  output logic              validW,
  output logic              misalignM,
  output logic              buserrM,
  mem_access_unit_if.master bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;

  logic [15:0]       r_cnt;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [BE_W-1:0]   r_mem_be;
  logic [DATA_W-1:0] r_mem_wdata, r_rdata, r_rdataW;
  logic [1:0]        r_size;
  logic              r_unsigned, r_err, r_validW, r_buserr;
  logic [OFF_W-1:0]  r_off;

  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_align_mask, w_addr_eff;
  logic [OFF_W-1:0]  w_off;
  logic [7:0]        w_mask8;
  logic [15:0]       w_be_wide;
  logic [DATA_W-1:0] w_wdata, w_shift, w_keep, w_ext;
  logic              w_sbit, w_trap, w_timeout, w_accept;

  // A dword on a 32-bit path can only ever be a word access.
  assign w_size = (sizeM == 2'b11 && DATA_W == 32) ? 2'b10 : sizeM;

`ifdef MEMU_MISALIGN_TRAP_EN
  logic w_misaligned;
  always_comb begin
    w_misaligned = 1'b0;
    case (sizeM)
      2'b01:   w_misaligned = addrM[0];
      2'b10:   w_misaligned = |addrM[1:0];
      2'b11:   w_misaligned = (DATA_W == 32) ? 1'b1 : |addrM[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end
  assign w_trap = reqM & w_misaligned;
`else
  assign w_trap = 1'b0;
`endif

  assign misalignM = w_trap;
  assign stallM    = reqM & (r_state != DONE) & ~w_trap;
  assign w_accept  = reqM & ~w_trap;
  assign w_timeout = (r_cnt == 16'(TIMEOUT - 1));

  always_comb begin
    w_align_mask = '1;
    w_mask8      = 8'h01;
    w_wdata      = wdataM;
    case (w_size)
      2'b00: begin w_mask8 = 8'h01; w_wdata = {BE_W{wdataM[7:0]}}; end
      2'b01: begin w_mask8 = 8'h03; w_align_mask = ~ADDR_W'(1); w_wdata = {(DATA_W/16){wdataM[15:0]}}; end
      2'b10: begin w_mask8 = 8'h0F; w_align_mask = ~ADDR_W'(3); w_wdata = {(DATA_W/32){wdataM[31:0]}}; end
      default: begin w_mask8 = 8'hFF; w_align_mask = ~ADDR_W'(7); w_wdata = wdataM; end
    endcase
    w_addr_eff = addrM & w_align_mask;
    w_off      = w_addr_eff[OFF_W-1:0];
    w_be_wide  = 16'(w_mask8) << w_off;
  end

  always_comb begin
    w_shift = r_rdata >> {r_off, 3'b000};
    w_keep  = '1;
    w_sbit  = w_shift[DATA_W-1];
    case (r_size)
      2'b00:   begin w_keep = DATA_W'(8'hFF);         w_sbit = w_shift[7];  end
      2'b01:   begin w_keep = DATA_W'(16'hFFFF);      w_sbit = w_shift[15]; end
      2'b10:   begin w_keep = DATA_W'(32'hFFFF_FFFF); w_sbit = w_shift[31]; end
      default: begin w_keep = '1;                     w_sbit = w_shift[DATA_W-1]; end
    endcase
    w_ext = (w_shift & w_keep) | ((~r_unsigned & w_sbit) ? ~w_keep : '0);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = BUSY;
      BUSY:    if (bus.mem_ack || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0; r_mem_req <= 1'b0; r_mem_we <= 1'b0; r_mem_addr <= '0;
      r_mem_be <= '0; r_mem_wdata <= '0; r_rdata <= '0; r_rdataW <= '0;
      r_size <= '0; r_unsigned <= 1'b0; r_off <= '0; r_err <= 1'b0;
      r_validW <= 1'b0; r_buserr <= 1'b0;
    end else begin
      r_validW <= 1'b0;
      r_buserr <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= weM;
          r_mem_addr  <= w_addr_eff & ~ADDR_W'(BE_W - 1);
          r_mem_be    <= w_be_wide[BE_W-1:0];
          r_mem_wdata <= w_wdata;
          r_size      <= w_size;
          r_unsigned  <= unsignedM;
          r_off       <= w_off;
          r_cnt       <= '0;
          r_err       <= 1'b0;
        end
        BUSY: begin
          // Ack is checked first so a response on the timeout cycle still completes.
          if (bus.mem_ack) begin
            r_rdata   <= bus.mem_rdata;
            r_mem_req <= 1'b0;
          end else if (w_timeout) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_buserr  <= 1'b1;
            r_mem_req <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DONE: begin
          r_rdataW <= w_ext;
          r_validW <= ~r_mem_we & ~r_err;
        end
        default: ;
      endcase
    end
  end

  assign rdataW        = r_rdataW;
  assign validW        = r_validW;
  assign buserrM       = r_buserr;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - bench for mem_access_unit: 32-bit (TIMEOUT=4) and 64-bit instances
module tb_mem_access_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sel64, req, we, uns, ack;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [63:0] wdata, rdata;

  logic        stall32, valid32, mis32, berr32, stall64, valid64, mis64, berr64;
  logic [31:0] rdataW32;
  logic [63:0] rdataW64;

  mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
  mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

  assign bus32.mem_ack   = ack & ~sel64;
  assign bus32.mem_rdata = rdata[31:0];
  assign bus64.mem_ack   = ack & sel64;
  assign bus64.mem_rdata = rdata;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .reset(reset), .reqM(req & ~sel64), .weM(we), .sizeM(size),
    .unsignedM(uns), .addrM(addr), .wdataM(wdata[31:0]), .stallM(stall32),
    .rdataW(rdataW32), .validW(valid32), .misalignM(mis32), .buserrM(berr32),
    .bus(bus32)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(255)) dut64 (
    .clk(clk), .reset(reset), .reqM(req & sel64), .weM(we), .sizeM(size),
    .unsignedM(uns), .addrM(addr), .wdataM(wdata), .stallM(stall64),
    .rdataW(rdataW64), .validW(valid64), .misalignM(mis64), .buserrM(berr64),
    .bus(bus64)
  );

  logic        cur_stall, cur_valid, cur_mis, cur_berr, cur_req, cur_we;
  logic [63:0] cur_rdataW, cur_wdata;
  logic [31:0] cur_addr;
  logic [7:0]  cur_be;

  always_comb begin
    if (sel64) begin
      cur_stall = stall64; cur_valid = valid64; cur_mis = mis64; cur_berr = berr64;
      cur_rdataW = rdataW64; cur_req = bus64.mem_req; cur_we = bus64.mem_we;
      cur_addr = bus64.mem_addr; cur_be = bus64.mem_be; cur_wdata = bus64.mem_wdata;
    end else begin
      cur_stall = stall32; cur_valid = valid32; cur_mis = mis32; cur_berr = berr32;
      cur_rdataW = {32'h0, rdataW32}; cur_req = bus32.mem_req; cur_we = bus32.mem_we;
      cur_addr = bus32.mem_addr; cur_be = {4'h0, bus32.mem_be}; cur_wdata = {32'h0, bus32.mem_wdata};
    end
  end

  typedef struct {
    bit          w64;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    bit          misal;
    logic [31:0] exp_addr;
    logic [7:0]  exp_be;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdataW;
  } vec_t;

  vec_t vecs[16];
  vec_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w64, bit w, logic [1:0] sz, bit u, logic [31:0] a,
                              logic [63:0] wd, logic [63:0] rd, bit mis, logic [31:0] ea,
                              logic [7:0] eb, logic [63:0] ew, logic [63:0] er);
    vec_t v;
    v.w64 = w64; v.we = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.misal = mis; v.exp_addr = ea; v.exp_be = eb; v.exp_wdata = ew; v.exp_rdataW = er;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    vec_t e;
    @(posedge clk); #1;
    sel64 = v.w64; req = 1'b1; we = v.we; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata;
`ifdef MEMU_MISALIGN_TRAP_EN
    if (v.misal) begin
      @(negedge clk);
      chk("trap_misalignM", cur_mis, 1'b1);
      chk("trap_stallM", cur_stall, 1'b0);
      @(posedge clk); #1 req = 1'b0;
      @(negedge clk);
      chk("trap_no_req", cur_req, 1'b0);
      chk("trap_validW", cur_valid, 1'b0);
      return;
    end
`endif
    sb_q.push_back(v);
    @(negedge clk);
    chk("idle_stallM", cur_stall, 1'b1);
    chk("misalignM", cur_mis, 1'b0);
    @(posedge clk); #1;
    ack = 1'b1; rdata = v.rdata;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("scoreboard_nonempty", 64'd0, 64'd1);
      e = v;
    end else begin
      e = sb_q.pop_front();
    end
    chk("busy_mem_req", cur_req, 1'b1);
    chk("busy_stallM", cur_stall, 1'b1);
    chk("mem_we", cur_we, e.we);
    chk("mem_addr", cur_addr, e.exp_addr);
    chk("mem_be", cur_be, e.exp_be);
    if (e.we) chk("mem_wdata", cur_wdata, e.exp_wdata);
    @(posedge clk); #1 ack = 1'b0;
    @(negedge clk);
    chk("done_mem_req", cur_req, 1'b0);
    chk("done_stallM", cur_stall, 1'b0);
    chk("done_validW", cur_valid, 1'b0);
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk("validW", cur_valid, !e.we);
    if (!e.we) chk("rdataW", cur_rdataW, e.exp_rdataW);
    @(posedge clk); #1;
    @(negedge clk);
    chk("validW_after", cur_valid, 1'b0);
  endtask

  task automatic timeout_seq();
    int n_req = 0, n_berr = 0, n_valid = 0;
    @(posedge clk); #1;
    sel64 = 1'b0; req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h40;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cur_req) n_req++;
      if (cur_valid) n_valid++;
      if (cur_berr) begin
        n_berr++;
        chk("timeout_stallM", cur_stall, 1'b0);
      end
      @(posedge clk); #1;
      if (n_berr != 0) req = 1'b0;
    end
    chk("timeout_req_cycles", n_req, 4);
    chk("timeout_buserr_pulses", n_berr, 1);
    chk("timeout_validW", n_valid, 0);
    chk("timeout_rdataW", cur_rdataW, 64'h0);
  endtask

  task automatic ack_wins_seq();
    @(posedge clk); #1;
    sel64 = 1'b0; req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h20;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 ack = 1'b1; rdata = 64'h5A5A_1234;
    @(posedge clk); #1 ack = 1'b0;
    @(negedge clk);
    chk("ackwin_buserrM", cur_berr, 1'b0);
    chk("ackwin_mem_req", cur_req, 1'b0);
    chk("ackwin_stallM", cur_stall, 1'b0);
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk("ackwin_validW", cur_valid, 1'b1);
    chk("ackwin_rdataW", cur_rdataW, 64'h5A5A_1234);
  endtask

  task automatic reset_busy_seq();
    @(posedge clk); #1;
    sel64 = 1'b0; req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h50;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; ack = 1'b1; rdata = 64'hFFFF_FFFF;
    @(negedge clk);
    chk("rst_mem_req", cur_req, 1'b0);
    chk("rst_mem_be", cur_be, 8'h0);
    chk("rst_mem_addr", cur_addr, 32'h0);
    chk("rst_rdataW", cur_rdataW, 64'h0);
    @(posedge clk); #1 ack = 1'b0;
    @(negedge clk);
    chk("rst_ack_ignored_req", cur_req, 1'b0);
    chk("rst_ack_ignored_valid", cur_valid, 1'b0);
    @(negedge clk);
    chk("rst_ack_ignored_valid2", cur_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1; sel64 = 1'b0; req = 1'b0; we = 1'b0; uns = 1'b0; ack = 1'b0;
    size = 2'b00; addr = '0; wdata = '0; rdata = '0;

    vecs[0]  = mk(0, 0, 2'b00, 0, 32'h103, 64'h0,        64'h80FF_FF00, 0, 32'h100, 8'h08, 64'h0,         64'hFFFF_FF80);
    vecs[1]  = mk(0, 1, 2'b01, 0, 32'h102, 64'hBEEF,     64'h0,         0, 32'h100, 8'h0C, 64'hBEEF_BEEF, 64'h0);
    vecs[2]  = mk(0, 0, 2'b00, 1, 32'h101, 64'h0,        64'h1234_A578, 0, 32'h100, 8'h02, 64'h0,         64'h0000_00A5);
    vecs[3]  = mk(0, 0, 2'b01, 0, 32'h100, 64'h0,        64'h0000_8001, 0, 32'h100, 8'h03, 64'h0,         64'hFFFF_8001);
    vecs[4]  = mk(0, 0, 2'b01, 1, 32'h102, 64'h0,        64'hF00D_1234, 0, 32'h100, 8'h0C, 64'h0,         64'h0000_F00D);
    vecs[5]  = mk(0, 0, 2'b10, 0, 32'h104, 64'h0,        64'hDEAD_BEEF, 0, 32'h104, 8'h0F, 64'h0,         64'hDEAD_BEEF);
    vecs[6]  = mk(0, 1, 2'b00, 0, 32'h201, 64'h1234_5677, 64'h0,        0, 32'h200, 8'h02, 64'h7777_7777, 64'h0);
    vecs[7]  = mk(0, 1, 2'b10, 0, 32'h300, 64'hCAFE_F00D, 64'h0,        0, 32'h300, 8'h0F, 64'hCAFE_F00D, 64'h0);
    vecs[8]  = mk(0, 0, 2'b10, 0, 32'h102, 64'h0,        64'h1122_3344, 1, 32'h100, 8'h0F, 64'h0,         64'h1122_3344);
    vecs[9]  = mk(0, 0, 2'b01, 0, 32'h103, 64'h0,        64'h8765_4321, 1, 32'h100, 8'h0C, 64'h0,         64'hFFFF_8765);
    vecs[10] = mk(1, 0, 2'b10, 1, 32'h4,   64'h0, 64'h8765_4321_0000_0000, 0, 32'h0, 8'hF0, 64'h0, 64'h0000_0000_8765_4321);
    vecs[11] = mk(1, 0, 2'b10, 0, 32'h4,   64'h0, 64'h8765_4321_0000_0000, 0, 32'h0, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321);
    vecs[12] = mk(1, 0, 2'b11, 0, 32'h8,   64'h0, 64'h0123_4567_89AB_CDEF, 0, 32'h8, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF);
    vecs[13] = mk(1, 1, 2'b01, 0, 32'h6,   64'hBEEF, 64'h0, 0, 32'h0, 8'hC0, 64'hBEEF_BEEF_BEEF_BEEF, 64'h0);
    vecs[14] = mk(1, 0, 2'b00, 0, 32'hF,   64'h0, 64'h7F00_0000_0000_0000, 0, 32'h8, 8'h80, 64'h0, 64'h0000_0000_0000_007F);
    vecs[15] = mk(1, 1, 2'b00, 0, 32'h3,   64'hA5, 64'h0, 0, 32'h0, 8'h08, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_stall32", stall32, 1'b0);
    chk("reset_valid32", valid32, 1'b0);
    chk("reset_rdataW32", rdataW32, 32'h0);
    chk("reset_buserr32", berr32, 1'b0);
    chk("reset_req32", bus32.mem_req, 1'b0);
    chk("reset_we32", bus32.mem_we, 1'b0);
    chk("reset_be32", bus32.mem_be, 4'h0);
    chk("reset_addr32", bus32.mem_addr, 32'h0);
    chk("reset_wdata32", bus32.mem_wdata, 32'h0);
    chk("reset_req64", bus64.mem_req, 1'b0);
    chk("reset_rdataW64", rdataW64, 64'h0);
    chk("reset_valid64", valid64, 1'b0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    timeout_seq();
    ack_wins_seq();
    reset_busy_seq();
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
